// File: rtl/cpu_controller.sv
// Instruction register, decoder and Moore sequencer for the datapath: one instruction per start,
// each phase (read A, read B, execute, write back) taking one clock.
module cpu_controller #(
    parameter logic [15:0] IR_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic        ill,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  vsel,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        StWait   = 3'd0,
        StDecode = 3'd1,
        StGetA   = 3'd2,
        StGetB   = 3'd3,
        StExec   = 3'd4,
        StWrReg  = 3'd5,
        StWrImm  = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q;

    logic [2:0] op3, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    assign op3 = ir_q[15:13];
    assign op  = ir_q[12:11];
    assign rn  = ir_q[10:8];
    assign rd  = ir_q[7:5];
    assign sh  = ir_q[4:3];
    assign rm  = ir_q[2:0];

    assign is_mov_imm = (op3 == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (op3 == 3'b110) && (op == 2'b00);
    assign is_alu     = (op3 == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StWait;
            ir_q    <= IR_RESET;
        end else begin
            state_q <= state_d;
            // IR only moves while idle so it stays stable across an instruction
            if (load && (state_q == StWait)) begin
                ir_q <= in;
            end
        end
    end

    always_comb begin
        state_d  = StWait;
        w        = 1'b0;
        ill      = 1'b0;
        readnum  = 3'b000;
        writenum = 3'b000;
        vsel     = 2'b00;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;

        case (state_q)
            StWait: begin
                w       = 1'b1;
                state_d = s ? StDecode : StWait;
            end
            StDecode: begin
                if (is_mov_imm) begin
                    state_d = StWrImm;
                end else if (is_mov_reg || is_mvn) begin
                    state_d = StGetB;
                end else if (is_alu) begin
                    state_d = StGetA;
                end else begin
                    ill     = 1'b1;
                    state_d = StWait;
                end
            end
            StGetA: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = StGetB;
            end
            StGetB: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = StExec;
            end
            StExec: begin
                shift   = sh;
                loadc   = 1'b1;
                asel    = is_mov_reg || is_mvn;
                ALUop   = is_alu ? op : 2'b00;
                loads   = is_cmp;
                state_d = is_cmp ? StWait : StWrReg;
            end
            StWrReg: begin
                writenum = rd;
                vsel     = 2'b00;
                write    = 1'b1;
                state_d  = StWait;
            end
            StWrImm: begin
                writenum = rn;
                vsel     = 2'b10;
                write    = 1'b1;
                state_d  = StWait;
            end
            default: state_d = StWait;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed instructions push per-cycle expected control vectors into a
// scoreboard queue tagged with the cycle they are due; a monitor compares on each falling edge.
module tb_cpu_controller;

    typedef struct packed {
        logic        w;
        logic        ill;
        logic [2:0]  rn;
        logic [2:0]  wn;
        logic [1:0]  vsel;
        logic        wr;
        logic        la;
        logic        lb;
        logic        lc;
        logic        ls;
        logic        asel;
        logic        bsel;
        logic [1:0]  sh;
        logic [1:0]  alu;
        logic [15:0] x8;
        logic [15:0] x5;
    } ctl_t;

    typedef struct {
        int    due;
        string tag;
        ctl_t  v;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w, ill, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;

    int   cyc;
    int   checks;
    int   failures;
    exp_t sb[$];

    cpu_controller #(
        .IR_RESET(16'h0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (in),
        .load    (load),
        .s       (s),
        .w       (w),
        .ill     (ill),
        .readnum (readnum),
        .writenum(writenum),
        .vsel    (vsel),
        .write   (write),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .shift   (shift),
        .ALUop   (ALUop),
        .sximm8  (sximm8),
        .sximm5  (sximm5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare the entry due this cycle against what the DUT presents.
    always @(negedge clk) begin
        ctl_t act;
        act = '{w: w, ill: ill, rn: readnum, wn: writenum, vsel: vsel, wr: write, la: loada,
                lb: loadb, lc: loadc, ls: loads, asel: asel, bsel: bsel, sh: shift, alu: ALUop,
                x8: sximm8, x5: sximm5};
        while (sb.size() > 0 && sb[0].due < cyc) begin
            failures = failures + 1;
            $display("FAIL %s missed: due cycle %0d, now %0d", sb[0].tag, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            checks = checks + 1;
            if (act !== sb[0].v) begin
                failures = failures + 1;
                $display("FAIL %s cyc=%0d got=%h expected=%h", sb[0].tag, cyc, act, sb[0].v);
            end
            void'(sb.pop_front());
        end
    end

    function automatic ctl_t busy(input logic [15:0] a, input logic [15:0] b);
        ctl_t c;
        c    = '0;
        c.x8 = a;
        c.x5 = b;
        return c;
    endfunction

    function automatic ctl_t idle(input logic [15:0] a, input logic [15:0] b);
        ctl_t c;
        c   = busy(a, b);
        c.w = 1'b1;
        return c;
    endfunction

    task automatic expect_at(input int due, input string tag, input ctl_t v);
        exp_t e;
        e.due = due;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] word);
        in   = word;
        load = 1'b1;
        s    = 1'b1;
        tick();
        load = 1'b0;
        s    = 1'b0;
    endtask

    initial begin
        int   b;
        ctl_t c;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        in       = 16'h0000;
        load     = 1'b0;
        s        = 1'b0;

        // Reset: idle, IR = 0, input activity ignored
        expect_at(1, "reset_idle", idle(16'h0000, 16'h0000));
        expect_at(2, "reset_idle2", idle(16'h0000, 16'h0000));
        tick();
        checks = checks + 1;
        if (w !== 1'b1 || write !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL reset_direct w=%b write=%b", w, write);
        end
        in   = 16'hFFFF;
        load = 1'b1;
        s    = 1'b1;
        tick();
        load    = 1'b0;
        s       = 1'b0;
        reset_n = 1'b1;

        // T1: MOV R0,#7
        b = cyc;
        expect_at(b + 1, "movi_decode", busy(16'h0007, 16'h0007));
        c = busy(16'h0007, 16'h0007); c.wn = 3'd0; c.vsel = 2'b10; c.wr = 1'b1;
        expect_at(b + 2, "movi_wrimm", c);
        expect_at(b + 3, "movi_wait", idle(16'h0007, 16'h0007));
        start(16'hD007);
        repeat (3) tick();
        checks = checks + 1;
        if (w !== 1'b1 || write !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL movi_direct w=%b write=%b", w, write);
        end

        // T2: ADD R2,R1,R0
        b = cyc;
        expect_at(b + 1, "add_decode", busy(16'h0040, 16'h0000));
        c = busy(16'h0040, 16'h0000); c.rn = 3'd1; c.la = 1'b1;
        expect_at(b + 2, "add_geta", c);
        c = busy(16'h0040, 16'h0000); c.rn = 3'd0; c.lb = 1'b1;
        expect_at(b + 3, "add_getb", c);
        c = busy(16'h0040, 16'h0000); c.lc = 1'b1;
        expect_at(b + 4, "add_exec", c);
        c = busy(16'h0040, 16'h0000); c.wn = 3'd2; c.wr = 1'b1;
        expect_at(b + 5, "add_wrreg", c);
        expect_at(b + 6, "add_wait", idle(16'h0040, 16'h0000));
        start(16'hA140);
        repeat (6) tick();

        // T3: CMP R0,R1
        b = cyc;
        expect_at(b + 1, "cmp_decode", busy(16'h0001, 16'h0001));
        c = busy(16'h0001, 16'h0001); c.rn = 3'd0; c.la = 1'b1;
        expect_at(b + 2, "cmp_geta", c);
        c = busy(16'h0001, 16'h0001); c.rn = 3'd1; c.lb = 1'b1;
        expect_at(b + 3, "cmp_getb", c);
        c = busy(16'h0001, 16'h0001); c.lc = 1'b1; c.ls = 1'b1; c.alu = 2'b01;
        expect_at(b + 4, "cmp_exec", c);
        expect_at(b + 5, "cmp_wait", idle(16'h0001, 16'h0001));
        start(16'hA801);
        repeat (5) tick();

        // T4a: MOV R1,R0,LSL
        b = cyc;
        expect_at(b + 1, "movr_decode", busy(16'h0028, 16'h0008));
        c = busy(16'h0028, 16'h0008); c.rn = 3'd0; c.lb = 1'b1;
        expect_at(b + 2, "movr_getb", c);
        c = busy(16'h0028, 16'h0008); c.lc = 1'b1; c.asel = 1'b1; c.sh = 2'b01;
        expect_at(b + 3, "movr_exec", c);
        c = busy(16'h0028, 16'h0008); c.wn = 3'd1; c.wr = 1'b1;
        expect_at(b + 4, "movr_wrreg", c);
        expect_at(b + 5, "movr_wait", idle(16'h0028, 16'h0008));
        start(16'hC028);
        repeat (5) tick();

        // T4b: illegal opcode
        b = cyc;
        c = busy(16'h0000, 16'h0000); c.ill = 1'b1;
        expect_at(b + 1, "ill_decode", c);
        expect_at(b + 2, "ill_wait", idle(16'h0000, 16'h0000));
        start(16'hE000);
        repeat (2) tick();

        // MVN R7,R2 with negative sximm8
        b = cyc;
        expect_at(b + 1, "mvn_decode", busy(16'hFFE2, 16'h0002));
        c = busy(16'hFFE2, 16'h0002); c.rn = 3'd2; c.lb = 1'b1;
        expect_at(b + 2, "mvn_getb", c);
        c = busy(16'hFFE2, 16'h0002); c.lc = 1'b1; c.asel = 1'b1; c.alu = 2'b11;
        expect_at(b + 3, "mvn_exec", c);
        c = busy(16'hFFE2, 16'h0002); c.wn = 3'd7; c.wr = 1'b1;
        expect_at(b + 4, "mvn_wrreg", c);
        expect_at(b + 5, "mvn_wait", idle(16'hFFE2, 16'h0002));
        start(16'hB8E2);
        repeat (5) tick();

        // Load without start only updates IR
        b = cyc;
        expect_at(b + 1, "load_only", idle(16'h0007, 16'h0007));
        expect_at(b + 2, "load_only2", idle(16'h0007, 16'h0007));
        in   = 16'hD007;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();

        // T5: reset during GET_B of ADD abandons it
        b = cyc;
        c = busy(16'h0040, 16'h0000); c.rn = 3'd1; c.la = 1'b1;
        expect_at(b + 2, "rst_geta", c);
        expect_at(b + 3, "rst_async", idle(16'h0000, 16'h0000));
        expect_at(b + 4, "rst_hold", idle(16'h0000, 16'h0000));
        expect_at(b + 5, "rst_after", idle(16'h0000, 16'h0000));
        expect_at(b + 6, "rst_nowrite", idle(16'h0000, 16'h0000));
        start(16'hA140);
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        checks = checks + 1;
        if (w !== 1'b1 || loadb !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL rst_direct w=%b loadb=%b", w, loadb);
        end
        tick();
        reset_n = 1'b1;
        repeat (3) tick();

        // T6: load during EXEC ignored; s held high re-executes
        b = cyc;
        for (int r = 0; r < 2; r++) begin
            int o;
            o = b + 6 * r;
            expect_at(o + 1, "rep_decode", busy(16'h0040, 16'h0000));
            c = busy(16'h0040, 16'h0000); c.rn = 3'd1; c.la = 1'b1;
            expect_at(o + 2, "rep_geta", c);
            c = busy(16'h0040, 16'h0000); c.rn = 3'd0; c.lb = 1'b1;
            expect_at(o + 3, "rep_getb", c);
            c = busy(16'h0040, 16'h0000); c.lc = 1'b1;
            expect_at(o + 4, "rep_exec", c);
            c = busy(16'h0040, 16'h0000); c.wn = 3'd2; c.wr = 1'b1;
            expect_at(o + 5, "rep_wrreg", c);
            expect_at(o + 6, "rep_wait", idle(16'h0040, 16'h0000));
        end
        expect_at(b + 13, "rep_stop", idle(16'h0040, 16'h0000));
        in   = 16'hA140;
        load = 1'b1;
        s    = 1'b1;
        tick();
        load = 1'b0;
        repeat (3) tick();
        in   = 16'hA1E0;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (7) tick();
        s = 1'b0;
        repeat (3) tick();
        checks = checks + 1;
        if (w !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL rep_direct w=%b", w);
        end

        while (sb.size() > 0) begin
            failures = failures + 1;
            $display("FAIL %s never compared: due cycle %0d", sb[0].tag, sb[0].due);
            void'(sb.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
